load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory-side counterpart of the register-file write port: accepts one load/store request at a time.
//  Drives a single-outstanding valid/ready data bus and returns load data, lane-aligned to bit 0,
//  to the regfile write port with size/extend tags. Extension itself is done by the regfile.
//  Sits between execute stage and data memory.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles in WAIT before busError; 0 disables the timeout
// PORTS
//  clk            in   1   clock, rising edge
//  resetN         in   1   reset, synchronous, active-low
//  reqValid       in   1   request valid
//  reqReady       out  1   request accepted when reqValid&&reqReady
//  reqStore       in   1   1=store, 0=load
//  reqAddr        in   32  byte address
//  reqStoreData   in   32  store data, LSB-aligned
//  reqSize        in   RegfileWriteSize    access size
//  reqExtend      in   RegfileWriteExtend  load extension, passed through
//  reqRd          in   5   load destination register
//  busValid       out  1   bus request valid
//  busReady       in   1   bus request accepted
//  busWrite       out  1   1=write
//  busAddr        out  32  word address {reqAddr[31:2],2'b00}
//  busWdata       out  32  lane-replicated store data
//  busByteEn      out  4   byte-lane enables
//  busRvalid      in   1   read data valid
//  busRdata       in   32  read word
//  rfWrite        out  1   regfile write pulse
//  rfRd           out  5   destination register
//  rfData         out  32  busRdata >> (8*addr[1:0])
//  rfWriteSize    out  RegfileWriteSize    = latched reqSize
//  rfWriteExtend  out  RegfileWriteExtend  = latched reqExtend
//  misaligned     out  1   one-cycle pulse on misaligned/illegal request
//  busError       out  1   one-cycle pulse on WAIT timeout
// BEHAVIOUR
//  Reset (resetN=0 at edge): state IDLE; busValid, rfWrite, misaligned and busError are 0;
//   all other registered outputs are 0. Reset mid-transaction aborts it. No write-back occurs.
//  Reset mid-transaction: busValid drops at the same edge. A later busRvalid arriving in IDLE is ignored.
//  States:
//   IDLE
//    - reqReady=1.
//    - On accept, latch all req* fields.
//    - Illegal request -> ERR: H with addr[0]=1, W with addr[1:0]!=0, or any SIZE_BIT access.
//    - Otherwise -> ISSUE.
//   ERR
//    - misaligned=1 for one cycle; no bus activity.
//    - -> IDLE.
//   ISSUE
//    - busValid=1; busAddr, busWrite, busWdata and busByteEn are held stable until busReady.
//    - On busReady: store -> IDLE; load -> WAIT with timeout counter cleared.
//   WAIT
//    - On busRvalid: register rfData/rfRd/size/extend and pulse rfWrite=1 the next cycle (in IDLE).
//    - Else counter++. If TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: busError pulse next cycle, -> IDLE, no rfWrite.
//  reqReady=0 in all states except IDLE. The rfWrite cycle is in IDLE, so a new request may be accepted in it.
//  Store lanes (off=addr[1:0]):
//   B: wdata={4{d[7:0]}},  byteEn=4'b0001<<off
//   H: wdata={2{d[15:0]}}, byteEn=4'b0011<<off
//   W: wdata=d,            byteEn=4'b1111
//  Loads: busByteEn=4'b1111, busWdata=0. Loads to rd=0 still execute and pulse rfWrite; the regfile discards them.
//  busRvalid outside WAIT is ignored.
//  Latency, zero-wait bus: accept cycle N; busValid N+1; busReady N+1; busRvalid N+2; rfWrite N+3.
//   Store done N+1; next accept N+2.
// STRUCTURE
//  Shared package typedefs.sv: RegfileWriteSize and RegfileWriteExtend (existing);
//   add LsuState_t {LSU_IDLE, LSU_ERR, LSU_ISSUE, LSU_WAIT}.
//  Sub-module lsu_lane_align: combinational store replicate/byteEn and load right-shift by offset.
// TESTING
//  1 Store B, addr=0x1003, d=0x000000A5, busReady at once
//    -> busAddr=0x1000, busByteEn=4'b1000, busWdata=0xA5A5A5A5, busValid 1 cycle.
//  2 Load H S_EXT rd=7, addr=0x2002, busRdata=0x8001_1234
//    -> rfWrite 1 cycle, rfRd=7, rfData[15:0]=0x8001, size=H, extend=S_EXT, at N+3.
//  3 Load W, addr=0x2001 -> misaligned pulse at N+1; no busValid; reqReady=1 at N+2.
//  4 Store W, busReady held 0 for 5 cycles -> busValid and busAddr/busWdata/busByteEn stable for all 6 cycles.
//  5 TIMEOUT_CYCLES=4, load, busRvalid never -> busError pulse 4 cycles after handshake; no rfWrite; back to IDLE.
//  6 resetN=0 while in WAIT, then busRvalid -> state IDLE, rfWrite stays 0, busValid 0.

Source files
------------

// File: rtl/typedefs.sv
// Shared types for the load/store path.
// Regfile write tags plus the LSU state encoding.
package typedefs;

   typedef enum logic [1:0] {
      SIZE_B   = 2'd0,
      SIZE_H   = 2'd1,
      SIZE_W   = 2'd2,
      SIZE_BIT = 2'd3
   } RegfileWriteSize;

   typedef enum logic {
      U_EXT = 1'b0,
      S_EXT = 1'b1
   } RegfileWriteExtend;

   typedef enum logic [1:0] {
      LSU_IDLE  = 2'd0,
      LSU_ERR   = 2'd1,
      LSU_ISSUE = 2'd2,
      LSU_WAIT  = 2'd3
   } LsuState_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between a 32-bit word bus and
// LSB-aligned register data.
module lsu_lane_align
   import typedefs::*;
(
   input  RegfileWriteSize i_size,
   input  logic            i_store,
   input  logic [1:0]      i_off,
   input  logic [31:0]     i_wdata,
   input  logic [31:0]     i_rdata,
   output logic [31:0]     o_wdata,
   output logic [3:0]      o_byteEn,
   output logic [31:0]     o_rdata
);

   // Store: replicate data into every lane, enable addressed lanes
   always_comb begin
      o_wdata  = 32'h0;
      o_byteEn = 4'b1111;
      if (i_store) begin
         case (i_size)
            SIZE_B: begin
               o_wdata  = {4{i_wdata[7:0]}};
               o_byteEn = 4'b0001 << i_off;
            end
            SIZE_H: begin
               o_wdata  = {2{i_wdata[15:0]}};
               o_byteEn = 4'b0011 << i_off;
            end
            SIZE_W: begin
               o_wdata  = i_wdata;
               o_byteEn = 4'b1111;
            end
            default: begin
               o_wdata  = 32'h0;
               o_byteEn = 4'b0000;
            end
         endcase
      end
   end

   // Load: bring the addressed byte lane down to bit 0
   always_comb begin
      o_rdata = i_rdata >> {i_off, 3'b000};
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between execute and
// data memory; returns lane-aligned load data to the regfile.
module load_store_unit
   import typedefs::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              reqValid,
   output logic              reqReady,
   input  logic              reqStore,
   input  logic [31:0]       reqAddr,
   input  logic [31:0]       reqStoreData,
   input  RegfileWriteSize   reqSize,
   input  RegfileWriteExtend reqExtend,
   input  logic [4:0]        reqRd,
   output logic              busValid,
   input  logic              busReady,
   output logic              busWrite,
   output logic [31:0]       busAddr,
   output logic [31:0]       busWdata,
   output logic [3:0]        busByteEn,
   input  logic              busRvalid,
   input  logic [31:0]       busRdata,
   output logic              rfWrite,
   output logic [4:0]        rfRd,
   output logic [31:0]       rfData,
   output RegfileWriteSize   rfWriteSize,
   output RegfileWriteExtend rfWriteExtend,
   output logic              misaligned,
   output logic              busError
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [CW-1:0] TO_LAST =
      CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   LsuState_t         r_state;
   LsuState_t         w_next;
   logic              r_store;
   logic [31:0]       r_addr;
   logic [31:0]       r_wdata;
   RegfileWriteSize   r_size;
   RegfileWriteExtend r_ext;
   logic [4:0]        r_rd;
   logic [CW-1:0]     r_cnt;
   logic              r_rfWrite;
   logic [4:0]        r_rfRd;
   logic [31:0]       r_rfData;
   RegfileWriteSize   r_rfSize;
   RegfileWriteExtend r_rfExt;
   logic              r_busError;
   logic              w_illegal;
   logic              w_timeout;
   logic [31:0]       w_wdata;
   logic [3:0]        w_byteEn;
   logic [31:0]       w_rdata;

   lsu_lane_align u_align (
      .i_size   (r_size),
      .i_store  (r_store),
      .i_off    (r_addr[1:0]),
      .i_wdata  (r_wdata),
      .i_rdata  (busRdata),
      .o_wdata  (w_wdata),
      .o_byteEn (w_byteEn),
      .o_rdata  (w_rdata)
   );

   // Misaligned halves/words and bit-size accesses are rejected
   always_comb begin
      w_illegal = (reqSize == SIZE_BIT)
               || (reqSize == SIZE_H && reqAddr[0])
               || (reqSize == SIZE_W && reqAddr[1:0] != 2'b00);
      w_timeout = TO_EN && (r_cnt == TO_LAST);
   end

   // State register
   always_ff @(posedge clk) begin
      if (!resetN) r_state <= LSU_IDLE;
      else         r_state <= w_next;
   end

   // Next state and state-decoded outputs
   always_comb begin
      w_next     = r_state;
      reqReady   = 1'b0;
      busValid   = 1'b0;
      misaligned = 1'b0;
      unique case (r_state)
         LSU_IDLE: begin
            reqReady = 1'b1;
            if (reqValid)
               w_next = w_illegal ? LSU_ERR : LSU_ISSUE;
         end
         LSU_ERR: begin
            misaligned = 1'b1;
            w_next     = LSU_IDLE;
         end
         LSU_ISSUE: begin
            busValid = 1'b1;
            if (busReady)
               w_next = r_store ? LSU_IDLE : LSU_WAIT;
         end
         LSU_WAIT: begin
            if (busRvalid || w_timeout)
               w_next = LSU_IDLE;
         end
      endcase
   end

   // Bus fields are only driven while a request is presented
   always_comb begin
      busWrite  = busValid & r_store;
      busAddr   = busValid ? {r_addr[31:2], 2'b00} : 32'h0;
      busWdata  = busValid ? w_wdata : 32'h0;
      busByteEn = busValid ? w_byteEn : 4'b0000;
   end

   // Request latch, timeout counter and write-back registers
   always_ff @(posedge clk) begin
      if (!resetN) begin
         r_store    <= 1'b0;
         r_addr     <= 32'h0;
         r_wdata    <= 32'h0;
         r_size     <= SIZE_B;
         r_ext      <= U_EXT;
         r_rd       <= 5'd0;
         r_cnt      <= '0;
         r_rfWrite  <= 1'b0;
         r_rfRd     <= 5'd0;
         r_rfData   <= 32'h0;
         r_rfSize   <= SIZE_B;
         r_rfExt    <= U_EXT;
         r_busError <= 1'b0;
      end else begin
         r_rfWrite  <= 1'b0;
         r_busError <= 1'b0;
         if (r_state == LSU_IDLE && reqValid) begin
            r_store <= reqStore;
            r_addr  <= reqAddr;
            r_wdata <= reqStoreData;
            r_size  <= reqSize;
            r_ext   <= reqExtend;
            r_rd    <= reqRd;
         end
         if (r_state == LSU_ISSUE)
            r_cnt <= '0;
         if (r_state == LSU_WAIT) begin
            if (busRvalid) begin
               r_rfWrite <= 1'b1;
               r_rfRd    <= r_rd;
               r_rfData  <= w_rdata;
               r_rfSize  <= r_size;
               r_rfExt   <= r_ext;
            end else begin
               r_cnt <= r_cnt + CW'(1);
               if (w_timeout)
                  r_busError <= 1'b1;
            end
         end
      end
   end

   assign rfWrite       = r_rfWrite;
   assign rfRd          = r_rfRd;
   assign rfData        = r_rfData;
   assign rfWriteSize   = r_rfSize;
   assign rfWriteExtend = r_rfExt;
   assign busError      = r_busError;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit.
// Built with a 4-cycle WAIT timeout.
module tb_load_store_unit;
   import typedefs::*;

   logic              clk = 1'b0;
   logic              resetN;
   logic              reqValid;
   logic              reqReady;
   logic              reqStore;
   logic [31:0]       reqAddr;
   logic [31:0]       reqStoreData;
   RegfileWriteSize   reqSize;
   RegfileWriteExtend reqExtend;
   logic [4:0]        reqRd;
   logic              busValid;
   logic              busReady;
   logic              busWrite;
   logic [31:0]       busAddr;
   logic [31:0]       busWdata;
   logic [3:0]        busByteEn;
   logic              busRvalid;
   logic [31:0]       busRdata;
   logic              rfWrite;
   logic [4:0]        rfRd;
   logic [31:0]       rfData;
   RegfileWriteSize   rfWriteSize;
   RegfileWriteExtend rfWriteExtend;
   logic              misaligned;
   logic              busError;

   int n_checks = 0;
   int n_fail   = 0;

   load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk           (clk),
      .resetN        (resetN),
      .reqValid      (reqValid),
      .reqReady      (reqReady),
      .reqStore      (reqStore),
      .reqAddr       (reqAddr),
      .reqStoreData  (reqStoreData),
      .reqSize       (reqSize),
      .reqExtend     (reqExtend),
      .reqRd         (reqRd),
      .busValid      (busValid),
      .busReady      (busReady),
      .busWrite      (busWrite),
      .busAddr       (busAddr),
      .busWdata      (busWdata),
      .busByteEn     (busByteEn),
      .busRvalid     (busRvalid),
      .busRdata      (busRdata),
      .rfWrite       (rfWrite),
      .rfRd          (rfRd),
      .rfData        (rfData),
      .rfWriteSize   (rfWriteSize),
      .rfWriteExtend (rfWriteExtend),
      .misaligned    (misaligned),
      .busError      (busError)
   );

   always #5 clk = ~clk;

   // Advance one cycle; outputs are observed 1ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic st, input logic [31:0] a,
                      input logic [31:0] d, input RegfileWriteSize sz,
                      input RegfileWriteExtend ex, input logic [4:0] rd);
      reqValid     = 1'b1;
      reqStore     = st;
      reqAddr      = a;
      reqStoreData = d;
      reqSize      = sz;
      reqExtend    = ex;
      reqRd        = rd;
   endtask

   task automatic test_reset();
      resetN = 1'b0;
      reqValid = 1'b0;
      reqStore = 1'b0;
      reqAddr = 32'h0;
      reqStoreData = 32'h0;
      reqSize = SIZE_B;
      reqExtend = U_EXT;
      reqRd = 5'd0;
      busReady = 1'b0;
      busRvalid = 1'b0;
      busRdata = 32'h0;
      tick();
      tick();
      resetN = 1'b1;
      tick();
      n_checks++;
      if ({reqReady, busValid, rfWrite, misaligned, busError} !== 5'b10000) begin
         n_fail++;
         $display("FAIL reset_ctl got=%b exp=10000",
                  {reqReady, busValid, rfWrite, misaligned, busError});
      end
      n_checks++;
      if ({busAddr, busWdata, rfData, rfRd, busByteEn} !== 105'h0) begin
         n_fail++;
         $display("FAIL reset_data addr=%h wd=%h rf=%h rd=%0d be=%b exp=0",
                  busAddr, busWdata, rfData, rfRd, busByteEn);
      end
   endtask

   task automatic test_store_byte();
      req(1'b1, 32'h0000_1003, 32'h0000_00A5, SIZE_B, U_EXT, 5'd0);
      busReady = 1'b1;
      tick();
      reqValid = 1'b0;
      n_checks++;
      if ({busValid, busWrite, busAddr, busByteEn, busWdata} !==
          {2'b11, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5}) begin
         n_fail++;
         $display("FAIL store_b v=%b w=%b a=%h be=%b wd=%h exp 1 1 00001000 1000 a5a5a5a5",
                  busValid, busWrite, busAddr, busByteEn, busWdata);
      end
      tick();
      busReady = 1'b0;
      n_checks++;
      if ({busValid, reqReady} !== 2'b01) begin
         n_fail++;
         $display("FAIL store_b_done v=%b rdy=%b exp v=0 rdy=1", busValid, reqReady);
      end
   endtask

   task automatic test_load_half();
      req(1'b0, 32'h0000_2002, 32'h0, SIZE_H, S_EXT, 5'd7);
      busReady = 1'b1;
      tick();
      reqValid = 1'b0;
      n_checks++;
      if ({busValid, busWrite, busAddr, busByteEn, busWdata} !==
          {2'b10, 32'h0000_2000, 4'b1111, 32'h0}) begin
         n_fail++;
         $display("FAIL load_h_bus v=%b w=%b a=%h be=%b wd=%h exp 1 0 00002000 1111 0",
                  busValid, busWrite, busAddr, busByteEn, busWdata);
      end
      tick();
      busReady = 1'b0;
      busRvalid = 1'b1;
      busRdata = 32'h8001_1234;
      n_checks++;
      if ({busValid, rfWrite} !== 2'b00) begin
         n_fail++;
         $display("FAIL load_h_wait v=%b rfw=%b exp 00", busValid, rfWrite);
      end
      tick();
      busRvalid = 1'b0;
      n_checks++;
      if ({rfWrite, rfRd, rfData, rfWriteSize, rfWriteExtend} !==
          {1'b1, 5'd7, 32'h0000_8001, SIZE_H, S_EXT}) begin
         n_fail++;
         $display("FAIL load_h_wb rfw=%b rd=%0d d=%h sz=%0d ex=%0d exp 1 7 00008001 1 1",
                  rfWrite, rfRd, rfData, rfWriteSize, rfWriteExtend);
      end
      tick();
      n_checks++;
      if (rfWrite !== 1'b0) begin
         n_fail++;
         $display("FAIL load_h_pulse rfw=%b exp 0", rfWrite);
      end
   endtask

   task automatic test_misaligned();
      req(1'b0, 32'h0000_2001, 32'h0, SIZE_W, U_EXT, 5'd3);
      busReady = 1'b1;
      tick();
      reqValid = 1'b0;
      n_checks++;
      if ({misaligned, busValid, reqReady} !== 3'b100) begin
         n_fail++;
         $display("FAIL misal_w mis=%b v=%b rdy=%b exp 100", misaligned, busValid, reqReady);
      end
      tick();
      n_checks++;
      if ({misaligned, busValid, reqReady} !== 3'b001) begin
         n_fail++;
         $display("FAIL misal_w_done mis=%b v=%b rdy=%b exp 001", misaligned, busValid, reqReady);
      end
      req(1'b1, 32'h0000_2003, 32'h0, SIZE_H, U_EXT, 5'd0);
      tick();
      reqValid = 1'b0;
      n_checks++;
      if ({misaligned, busValid} !== 2'b10) begin
         n_fail++;
         $display("FAIL misal_h mis=%b v=%b exp 10", misaligned, busValid);
      end
      tick();
      busReady = 1'b0;
   endtask

   task automatic test_store_stall();
      req(1'b1, 32'h0000_3000, 32'hDEAD_BEEF, SIZE_W, U_EXT, 5'd0);
      busReady = 1'b0;
      tick();
      reqValid = 1'b0;
      reqAddr = 32'h0;
      reqStoreData = 32'h0;
      for (int i = 0; i < 6; i++) begin
         if (i == 5) busReady = 1'b1;
         n_checks++;
         if ({busValid, busWrite, busAddr, busWdata, busByteEn} !==
             {2'b11, 32'h0000_3000, 32'hDEAD_BEEF, 4'b1111}) begin
            n_fail++;
            $display("FAIL stall_%0d v=%b w=%b a=%h wd=%h be=%b exp 1 1 00003000 deadbeef 1111",
                     i, busValid, busWrite, busAddr, busWdata, busByteEn);
         end
         tick();
      end
      busReady = 1'b0;
      n_checks++;
      if ({busValid, reqReady} !== 2'b01) begin
         n_fail++;
         $display("FAIL stall_done v=%b rdy=%b exp 01", busValid, reqReady);
      end
   endtask

   task automatic test_timeout();
      req(1'b0, 32'h0000_4000, 32'h0, SIZE_W, U_EXT, 5'd9);
      busReady = 1'b1;
      tick();
      reqValid = 1'b0;
      tick();
      busReady = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if ({busError, busValid, reqReady} !== 3'b000) begin
            n_fail++;
            $display("FAIL timeout_wait_%0d err=%b v=%b rdy=%b exp 000",
                     i, busError, busValid, reqReady);
         end
         tick();
      end
      n_checks++;
      if ({busError, rfWrite, reqReady} !== 3'b101) begin
         n_fail++;
         $display("FAIL timeout_err err=%b rfw=%b rdy=%b exp 101", busError, rfWrite, reqReady);
      end
      tick();
      n_checks++;
      if ({busError, rfWrite} !== 2'b00) begin
         n_fail++;
         $display("FAIL timeout_pulse err=%b rfw=%b exp 00", busError, rfWrite);
      end
   endtask

   task automatic test_reset_in_wait();
      req(1'b0, 32'h0000_4004, 32'h0, SIZE_W, U_EXT, 5'd5);
      busReady = 1'b1;
      tick();
      reqValid = 1'b0;
      tick();
      busReady = 1'b0;
      resetN = 1'b0;
      tick();
      resetN = 1'b1;
      busRvalid = 1'b1;
      busRdata = 32'h1234_5678;
      n_checks++;
      if ({busValid, rfWrite, reqReady} !== 3'b001) begin
         n_fail++;
         $display("FAIL rst_wait v=%b rfw=%b rdy=%b exp 001", busValid, rfWrite, reqReady);
      end
      tick();
      busRvalid = 1'b0;
      n_checks++;
      if ({rfWrite, rfData} !== 33'h0) begin
         n_fail++;
         $display("FAIL rst_wait_rv rfw=%b d=%h exp 0 0", rfWrite, rfData);
      end
   endtask

   task automatic test_back_to_back();
      req(1'b0, 32'h0000_5001, 32'h0, SIZE_B, U_EXT, 5'd0);
      busReady = 1'b1;
      tick();
      reqValid = 1'b0;
      tick();
      busReady = 1'b0;
      busRvalid = 1'b1;
      busRdata = 32'h1122_3344;
      tick();
      busRvalid = 1'b0;
      n_checks++;
      if ({rfWrite, rfRd, rfData, reqReady} !== {1'b1, 5'd0, 32'h0011_2233, 1'b1}) begin
         n_fail++;
         $display("FAIL b2b_wb rfw=%b rd=%0d d=%h rdy=%b exp 1 0 00112233 1",
                  rfWrite, rfRd, rfData, reqReady);
      end
      req(1'b1, 32'h0000_6002, 32'h0000_BEEF, SIZE_H, U_EXT, 5'd0);
      busReady = 1'b1;
      tick();
      reqValid = 1'b0;
      n_checks++;
      if ({busValid, busAddr, busByteEn, busWdata, rfWrite} !==
          {1'b1, 32'h0000_6000, 4'b1100, 32'hBEEF_BEEF, 1'b0}) begin
         n_fail++;
         $display("FAIL b2b_store v=%b a=%h be=%b wd=%h rfw=%b exp 1 00006000 1100 beefbeef 0",
                  busValid, busAddr, busByteEn, busWdata, rfWrite);
      end
      tick();
      busReady = 1'b0;
   endtask

   initial begin
      test_reset();
      test_store_byte();
      test_load_half();
      test_misaligned();
      test_store_stall();
      test_timeout();
      test_reset_in_wait();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
